// File: rtl/trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_ctrl_if
// Groups every non-clock/reset signal of trap_ctrl.
//   Commit side : inst_valid, inst_pc, inst_raw, excp_illegal/ebreak/ecall, mret,
//                 flush, stall
//   Interrupts  : irq_ext, irq_soft, irq_timer (level requests)
//   CSR read    : mstatus_rd_data, mie_rd_data, mtvec_rd_data, mepc_rd_data
//   CSR write   : excp_enter, mstatus_wr_ena, mstatus/mepc/mcause/mtval_wr_data
//   Fetch       : redirect_valid, redirect_pc, redirect_ready
// slave  modport : the trap controller's view.
// master modport : the surrounding pipeline / csrfile / fetch view.
// -----------------------------------------------------------------------------
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            inst_valid;
  logic [XLEN-1:0] inst_pc;
  logic [31:0]     inst_raw;
  logic            excp_illegal;
  logic            excp_ebreak;
  logic            excp_ecall;
  logic            mret;
  logic            irq_ext;
  logic            irq_soft;
  logic            irq_timer;
  logic [XLEN-1:0] mstatus_rd_data;
  logic [XLEN-1:0] mie_rd_data;
  logic [XLEN-1:0] mtvec_rd_data;
  logic [XLEN-1:0] mepc_rd_data;
  logic            excp_enter;
  logic            mstatus_wr_ena;
  logic [XLEN-1:0] mstatus_wr_data;
  logic [XLEN-1:0] mepc_wr_data;
  logic [XLEN-1:0] mcause_wr_data;
  logic [XLEN-1:0] mtval_wr_data;
  logic            flush;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport slave (
    input  inst_valid, inst_pc, inst_raw,
    input  excp_illegal, excp_ebreak, excp_ecall, mret,
    input  irq_ext, irq_soft, irq_timer,
    input  mstatus_rd_data, mie_rd_data, mtvec_rd_data, mepc_rd_data,
    output excp_enter, mstatus_wr_ena,
    output mstatus_wr_data, mepc_wr_data, mcause_wr_data, mtval_wr_data,
    output flush, stall,
    output redirect_valid, redirect_pc,
    input  redirect_ready
  );

  modport master (
    output inst_valid, inst_pc, inst_raw,
    output excp_illegal, excp_ebreak, excp_ecall, mret,
    output irq_ext, irq_soft, irq_timer,
    output mstatus_rd_data, mie_rd_data, mtvec_rd_data, mepc_rd_data,
    input  excp_enter, mstatus_wr_ena,
    input  mstatus_wr_data, mepc_wr_data, mcause_wr_data, mtval_wr_data,
    input  flush, stall,
    input  redirect_valid, redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap controller in front of csrfile. At commit it picks between
// enabled interrupts, synchronous exceptions and mret, kills the committing
// instruction, strobes the CSR side effects for one cycle and then holds a PC
// redirect to fetch until it is accepted. The pipeline is stalled throughout.
//
// Ports:
//   clk    - clock
//   rst    - synchronous, active-high reset
//   bus_io - trap_ctrl_if.slave (commit, interrupt, CSR and redirect signals)
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int XLEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  trap_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_MRET = 2'd2,
    ST_JUMP = 2'd3
  } state_e;

  localparam logic [3:0] CAUSE_EXT   = 4'd11;
  localparam logic [3:0] CAUSE_SOFT  = 4'd3;
  localparam logic [3:0] CAUSE_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_ILL   = 4'd2;
  localparam logic [3:0] CAUSE_BRK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL = 4'd11;

  // MPIE <- MIE, MIE <- 0, MPP <- M; everything else untouched.
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MIE <- MPIE, MPIE <- 1, MPP <- M; everything else untouched.
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      irq_q;
  logic [2:0]      irq_en_s;
  logic            irq_pend_s;
  logic            take_s;
  logic            is_int_s;
  logic            do_mret_s;
  logic [3:0]      cause_s;
  logic [XLEN-1:0] mtval_s;
  logic [XLEN-1:0] tvec_base_s;
  logic [XLEN-1:0] trap_target_s;

  logic [XLEN-1:0] mstatus_wr_q, mstatus_wr_d;
  logic [XLEN-1:0] mepc_wr_q,    mepc_wr_d;
  logic [XLEN-1:0] mcause_wr_q,  mcause_wr_d;
  logic [XLEN-1:0] mtval_wr_q,   mtval_wr_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            excp_enter_s;
  logic            mstatus_wr_ena_s;
  logic            redirect_valid_s;
  logic            stall_s;

  // Only MEIE/MSIE/MTIE of mie are consulted.
  logic            unused_mie_s;
  assign unused_mie_s = ^bus_io.mie_rd_data;

  // Interrupt pin sampler; keeps sampling in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 3'b000;
    end else begin
      irq_q <= {bus_io.irq_ext, bus_io.irq_soft, bus_io.irq_timer};
    end
  end

  // Take decision: interrupts beat exceptions, exceptions beat mret; IDLE only.
  always_comb begin
    irq_en_s   = irq_q & {bus_io.mie_rd_data[11], bus_io.mie_rd_data[3], bus_io.mie_rd_data[7]};
    irq_pend_s = bus_io.mstatus_rd_data[3] & (irq_en_s != 3'b000);
    take_s     = 1'b0;
    is_int_s   = 1'b0;
    do_mret_s  = 1'b0;
    cause_s    = 4'd0;
    mtval_s    = {XLEN{1'b0}};
    if ((state_q == ST_IDLE) && bus_io.inst_valid) begin
      if (irq_pend_s) begin
        take_s   = 1'b1;
        is_int_s = 1'b1;
        if (irq_en_s[2]) begin
          cause_s = CAUSE_EXT;
        end else if (irq_en_s[1]) begin
          cause_s = CAUSE_SOFT;
        end else begin
          cause_s = CAUSE_TIMER;
        end
      end else if (bus_io.excp_illegal) begin
        take_s  = 1'b1;
        cause_s = CAUSE_ILL;
        mtval_s = {{(XLEN-32){1'b0}}, bus_io.inst_raw};
      end else if (bus_io.excp_ebreak) begin
        take_s  = 1'b1;
        cause_s = CAUSE_BRK;
        mtval_s = bus_io.inst_pc;
      end else if (bus_io.excp_ecall) begin
        take_s  = 1'b1;
        cause_s = CAUSE_ECALL;
      end else if (bus_io.mret) begin
        do_mret_s = 1'b1;
      end else begin
        take_s = 1'b0;
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // Trap vector: vectored mode offsets interrupts only, by 4*cause.
  always_comb begin
    tvec_base_s = {bus_io.mtvec_rd_data[XLEN-1:2], 2'b00};
    if (is_int_s && (bus_io.mtvec_rd_data[1:0] == 2'b01)) begin
      trap_target_s = tvec_base_s + {{(XLEN-6){1'b0}}, cause_s, 2'b00};
    end else begin
      trap_target_s = tvec_base_s;
    end
  end

  // Snapshot of write data and target at the take cycle; held otherwise.
  always_comb begin
    mstatus_wr_d  = mstatus_wr_q;
    mepc_wr_d     = mepc_wr_q;
    mcause_wr_d   = mcause_wr_q;
    mtval_wr_d    = mtval_wr_q;
    redirect_pc_d = redirect_pc_q;
    if (take_s) begin
      mstatus_wr_d  = mstatus_on_trap(bus_io.mstatus_rd_data);
      mepc_wr_d     = bus_io.inst_pc;
      mcause_wr_d   = {is_int_s, {(XLEN-5){1'b0}}, cause_s};
      mtval_wr_d    = mtval_s;
      redirect_pc_d = trap_target_s;
    end else if (do_mret_s) begin
      mstatus_wr_d  = mstatus_on_mret(bus_io.mstatus_rd_data);
      redirect_pc_d = bus_io.mepc_rd_data;
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
  end

  // Snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_wr_q  <= {XLEN{1'b0}};
      mepc_wr_q     <= {XLEN{1'b0}};
      mcause_wr_q   <= {XLEN{1'b0}};
      mtval_wr_q    <= {XLEN{1'b0}};
      redirect_pc_q <= {XLEN{1'b0}};
    end else begin
      mstatus_wr_q  <= mstatus_wr_d;
      mepc_wr_q     <= mepc_wr_d;
      mcause_wr_q   <= mcause_wr_d;
      mtval_wr_q    <= mtval_wr_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          state_d = ST_TRAP;
        end else if (do_mret_s) begin
          state_d = ST_MRET;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: state_d = ST_JUMP;
      ST_MRET: state_d = ST_JUMP;
      ST_JUMP: begin
        if (bus_io.redirect_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_JUMP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    excp_enter_s     = 1'b0;
    mstatus_wr_ena_s = 1'b0;
    redirect_valid_s = 1'b0;
    stall_s          = 1'b1;
    case (state_q)
      ST_IDLE: stall_s = 1'b0;
      ST_TRAP: begin
        excp_enter_s     = 1'b1;
        mstatus_wr_ena_s = 1'b1;
      end
      ST_MRET: mstatus_wr_ena_s = 1'b1;
      ST_JUMP: redirect_valid_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
  end

  assign bus_io.excp_enter      = excp_enter_s;
  assign bus_io.mstatus_wr_ena  = mstatus_wr_ena_s;
  assign bus_io.mstatus_wr_data = mstatus_wr_q;
  assign bus_io.mepc_wr_data    = mepc_wr_q;
  assign bus_io.mcause_wr_data  = mcause_wr_q;
  assign bus_io.mtval_wr_data   = mtval_wr_q;
  assign bus_io.redirect_valid  = redirect_valid_s;
  assign bus_io.redirect_pc     = redirect_pc_q;
  assign bus_io.stall           = stall_s;
  // Combinational kill so the committing instruction never retires.
  assign bus_io.flush           = take_s | do_mret_s;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Directed bench for trap_ctrl. A behavioural model tracks each trap/mret as a
// record (what csrfile must receive, where fetch must go) plus a timeline
// position, and is compared with the DUT every cycle. Directed steps also pin
// hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  trap_ctrl_if #(.XLEN(64)) bus ();

  trap_ctrl #(.XLEN(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: compares on every negedge, then advances using the
  // inputs that the next posedge will sample.
  // ---------------------------------------------------------------------------
  int          m_ph;      // 0 = free, 1 = CSR write cycle, 2 = redirect pending
  bit          m_trap;
  bit          m_zero;
  logic [63:0] m_mst, m_mepc, m_mcause, m_mtval, m_tgt;
  logic [2:0]  m_irq;

  initial begin : model
    bit          cond [6];
    int          cause_tab [6];
    bit          take, isint, ismret;
    int          sel;
    logic [2:0]  en;
    logic [63:0] ms, base;
    m_ph = 0; m_trap = 1'b0; m_zero = 1'b0; m_irq = 3'b000;
    m_mst = 64'd0; m_mepc = 64'd0; m_mcause = 64'd0; m_mtval = 64'd0; m_tgt = 64'd0;
    cause_tab = '{11, 3, 7, 2, 3, 11};
    forever begin
      @(negedge clk);
      // candidate list, highest priority first
      en      = m_irq & {bus.mie_rd_data[11], bus.mie_rd_data[3], bus.mie_rd_data[7]};
      cond[0] = bus.mstatus_rd_data[3] & en[2];
      cond[1] = bus.mstatus_rd_data[3] & en[1];
      cond[2] = bus.mstatus_rd_data[3] & en[0];
      cond[3] = bus.excp_illegal;
      cond[4] = bus.excp_ebreak;
      cond[5] = bus.excp_ecall;
      sel = -1;
      for (int i = 5; i >= 0; i--) if (cond[i]) sel = i;
      take   = (m_ph == 0) && bus.inst_valid && (sel >= 0);
      ismret = (m_ph == 0) && bus.inst_valid && (sel < 0) && bus.mret;
      isint  = (sel >= 0) && (sel < 3);

      chk("flush", {63'd0, bus.flush}, {63'd0, take | ismret});
      chk("stall", {63'd0, bus.stall}, {63'd0, m_ph != 0});
      chk("excp_enter", {63'd0, bus.excp_enter}, {63'd0, (m_ph == 1) && m_trap});
      chk("mstatus_wr_ena", {63'd0, bus.mstatus_wr_ena}, {63'd0, m_ph == 1});
      chk("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, m_ph == 2});
      if (m_ph == 1) begin
        chk("mstatus_wr_data", bus.mstatus_wr_data, m_mst);
        if (m_trap) begin
          chk("mepc_wr_data", bus.mepc_wr_data, m_mepc);
          chk("mcause_wr_data", bus.mcause_wr_data, m_mcause);
          chk("mtval_wr_data", bus.mtval_wr_data, m_mtval);
        end
      end
      if (m_ph == 2) chk("redirect_pc", bus.redirect_pc, m_tgt);
      if (m_zero) begin
        chk("rst_mstatus_wr", bus.mstatus_wr_data, 64'd0);
        chk("rst_mepc_wr", bus.mepc_wr_data, 64'd0);
        chk("rst_mcause_wr", bus.mcause_wr_data, 64'd0);
        chk("rst_mtval_wr", bus.mtval_wr_data, 64'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 64'd0);
      end

      if (rst) begin
        m_ph = 0; m_zero = 1'b1; m_irq = 3'b000;
      end else begin
        m_zero = 1'b0;
        if (m_ph == 0) begin
          if (take) begin
            ms = bus.mstatus_rd_data;
            ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
            m_trap   = 1'b1;
            m_mst    = ms;
            m_mepc   = bus.inst_pc;
            m_mcause = (isint ? 64'h8000_0000_0000_0000 : 64'd0) | 64'(cause_tab[sel]);
            m_mtval  = (sel == 3) ? {32'd0, bus.inst_raw} : ((sel == 4) ? bus.inst_pc : 64'd0);
            base     = bus.mtvec_rd_data & ~64'h3;
            m_tgt    = (isint && bus.mtvec_rd_data[1:0] == 2'b01) ? base + 64'(4 * cause_tab[sel]) : base;
            m_ph     = 1;
          end else if (ismret) begin
            ms = bus.mstatus_rd_data;
            ms[3] = ms[7]; ms[7] = 1'b1; ms[12:11] = 2'b11;
            m_trap = 1'b0;
            m_mst  = ms;
            m_tgt  = bus.mepc_rd_data;
            m_ph   = 1;
          end
        end else if (m_ph == 1) begin
          m_ph = 2;
        end else if (bus.redirect_ready) begin
          m_ph = 0;
        end
        m_irq = {bus.irq_ext, bus.irq_soft, bus.irq_timer};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 time unit after posedge; literal checks
  // at +3, i.e. well before the model's negedge compare.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inst();
    bus.inst_valid   = 1'b0;
    bus.excp_illegal = 1'b0;
    bus.excp_ebreak  = 1'b0;
    bus.excp_ecall   = 1'b0;
    bus.mret         = 1'b0;
  endtask

  int held;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    clr_inst();
    bus.inst_pc = 64'd0; bus.inst_raw = 32'd0;
    bus.irq_ext = 1'b0; bus.irq_soft = 1'b0; bus.irq_timer = 1'b0;
    bus.mstatus_rd_data = 64'd0; bus.mie_rd_data = 64'd0;
    bus.mtvec_rd_data = 64'd0; bus.mepc_rd_data = 64'd0;
    bus.redirect_ready = 1'b1;

    // reset state
    tick(); tick();
    #2;
    chk("lit_rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("lit_rst_rv", {63'd0, bus.redirect_valid}, 64'd0);
    chk("lit_rst_excp_enter", {63'd0, bus.excp_enter}, 64'd0);
    chk("lit_rst_mcause", bus.mcause_wr_data, 64'd0);
    tick(); rst = 1'b0;
    tick();

    // ecall; a second exception in the write cycle must be ignored
    bus.mstatus_rd_data = 64'h8; bus.mtvec_rd_data = 64'h8000_0100;
    bus.inst_pc = 64'h8000_0010; bus.inst_raw = 32'h0000_0073;
    bus.inst_valid = 1'b1; bus.excp_ecall = 1'b1;
    #2 chk("lit_ecall_flush", {63'd0, bus.flush}, 64'd1);
    tick();
    bus.excp_ecall = 1'b0; bus.excp_illegal = 1'b1;
    #2;
    chk("lit_ecall_busy_flush", {63'd0, bus.flush}, 64'd0);
    chk("lit_ecall_enter", {63'd0, bus.excp_enter}, 64'd1);
    chk("lit_ecall_mepc", bus.mepc_wr_data, 64'h8000_0010);
    chk("lit_ecall_mcause", bus.mcause_wr_data, 64'd11);
    chk("lit_ecall_mtval", bus.mtval_wr_data, 64'd0);
    chk("lit_ecall_mstatus", bus.mstatus_wr_data, 64'h1880);
    tick(); clr_inst();
    #2 chk("lit_ecall_target", bus.redirect_pc, 64'h8000_0100);
    tick();

    // illegal instruction
    bus.inst_pc = 64'h40; bus.inst_raw = 32'hFFFF_FFFF;
    bus.inst_valid = 1'b1; bus.excp_illegal = 1'b1;
    #2 chk("lit_ill_flush", {63'd0, bus.flush}, 64'd1);
    tick(); clr_inst();
    #2;
    chk("lit_ill_mcause", bus.mcause_wr_data, 64'd2);
    chk("lit_ill_mtval", bus.mtval_wr_data, 64'h0000_0000_FFFF_FFFF);
    tick(); tick();

    // timer interrupt, vectored mtvec
    bus.mie_rd_data = 64'h80; bus.mstatus_rd_data = 64'h8; bus.mtvec_rd_data = 64'h1001;
    bus.irq_timer = 1'b1;
    tick();
    bus.inst_pc = 64'h200; bus.inst_raw = 32'h0000_0013; bus.inst_valid = 1'b1;
    tick(); clr_inst();
    #2;
    chk("lit_tmr_mcause", bus.mcause_wr_data, 64'h8000_0000_0000_0007);
    chk("lit_tmr_mepc", bus.mepc_wr_data, 64'h200);
    tick();
    #2 chk("lit_tmr_target", bus.redirect_pc, 64'h101C);
    tick();

    // same with MIE=0: no trap
    bus.mstatus_rd_data = 64'h0; bus.inst_valid = 1'b1;
    #2 chk("lit_tmr_masked_flush", {63'd0, bus.flush}, 64'd0);
    tick(); clr_inst(); bus.irq_timer = 1'b0;
    #2 chk("lit_tmr_masked_stall", {63'd0, bus.stall}, 64'd0);
    tick();

    // ext + soft + ebreak: ext wins
    bus.mstatus_rd_data = 64'h8; bus.mie_rd_data = 64'h888;
    bus.irq_ext = 1'b1; bus.irq_soft = 1'b1;
    tick();
    bus.inst_pc = 64'h500; bus.inst_valid = 1'b1; bus.excp_ebreak = 1'b1;
    tick(); clr_inst(); bus.irq_ext = 1'b0; bus.irq_soft = 1'b0;
    #2 chk("lit_ext_mcause", bus.mcause_wr_data, 64'h8000_0000_0000_000B);
    tick(); tick(); tick();

    // mret
    bus.mstatus_rd_data = 64'h1880; bus.mepc_rd_data = 64'h3000;
    bus.inst_valid = 1'b1; bus.mret = 1'b1;
    #2 chk("lit_mret_flush", {63'd0, bus.flush}, 64'd1);
    tick(); clr_inst();
    #2;
    chk("lit_mret_wr_ena", {63'd0, bus.mstatus_wr_ena}, 64'd1);
    chk("lit_mret_mstatus", bus.mstatus_wr_data, 64'h1888);
    chk("lit_mret_enter", {63'd0, bus.excp_enter}, 64'd0);
    tick();
    #2 chk("lit_mret_target", bus.redirect_pc, 64'h3000);
    tick();

    // redirect back-pressure: ready low for 5 JUMP cycles
    bus.mstatus_rd_data = 64'h8; bus.redirect_ready = 1'b0;
    bus.inst_pc = 64'h600; bus.inst_valid = 1'b1; bus.excp_ecall = 1'b1;
    tick(); clr_inst();
    tick();
    held = 0;
    for (int i = 0; i < 20; i++) begin
      bus.redirect_ready = (held >= 5);
      #2;
      if (bus.redirect_valid && bus.stall) held++;
      else break;
      tick();
    end
    chk("lit_hold_cycles", 64'(held), 64'd6);
    chk("lit_hold_idle_stall", {63'd0, bus.stall}, 64'd0);
    tick();

    // reset while in JUMP
    bus.redirect_ready = 1'b0;
    bus.inst_pc = 64'h700; bus.inst_valid = 1'b1; bus.excp_ecall = 1'b1;
    tick(); clr_inst();
    tick();
    #2 chk("lit_jump_before_rst", {63'd0, bus.redirect_valid}, 64'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    #2;
    chk("lit_jrst_rv", {63'd0, bus.redirect_valid}, 64'd0);
    chk("lit_jrst_stall", {63'd0, bus.stall}, 64'd0);
    chk("lit_jrst_pc", bus.redirect_pc, 64'd0);
    chk("lit_jrst_wr_ena", {63'd0, bus.mstatus_wr_ena}, 64'd0);
    bus.redirect_ready = 1'b1;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
